// File: rtl/xga_mem_pkg.sv
// Shared constants and types for the XGA memory-side responder.
package xga_mem_pkg;

    // Single command word layout: {write, word address, write data}
    localparam int CMD_W        = 41;
    localparam int CMD_WE_BIT   = 40;
    localparam int CMD_ADDR_MSB = 39;
    localparam int CMD_ADDR_LSB = 16;

    // Burst request word: [23:0] aligned word address, upper byte reserved
    localparam int BURST_REQ_W  = 32;
    localparam int BURST_LEN    = 8;
    localparam int BEAT_W       = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2,
        PUSH   = 2'd3
    } state_e;

endpackage

// File: rtl/xga_burst_packer.sv
// Collects the beats of one burst read into a wide response word.
// Beat 0 lands in the least significant slot.
module xga_burst_packer #(
    parameter int DATA_W = 16,
    parameter int BEATS  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        beat_valid,
    input  logic [DATA_W-1:0]           data,
    output logic [BEATS*DATA_W-1:0]     data_128,
    output logic [$clog2(BEATS)-1:0]    beat,
    output logic                        last_beat
);

    localparam int BW = $clog2(BEATS);

    logic [BW-1:0]           beat_q, beat_d;
    logic [BEATS*DATA_W-1:0] data_q, data_d;

    // Next beat index and slot write; clear wins so a new burst never sees old beats
    always_comb begin
        beat_d = beat_q;
        data_d = data_q;
        if (clear) begin
            beat_d = '0;
            data_d = '0;
        end else if (beat_valid) begin
            beat_d = beat_q + 1'b1;
            data_d[beat_q*DATA_W +: DATA_W] = data;
        end
    end

    // Beat counter and assembly register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            data_q <= '0;
        end else begin
            beat_q <= beat_d;
            data_q <= data_d;
        end
    end

    assign data_128  = data_q;
    assign beat      = beat_q;
    assign last_beat = (beat_q == BW'(BEATS - 1));

endmodule

// File: rtl/xga_mem_responder.sv
// Memory-side responder: pops single commands and burst requests, runs them
// on the req/ack memory port and pushes read data into the response FIFOs.
module xga_mem_responder #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                        clk,
    input  logic                        reset_n_i,
    input  logic [ADDR_W+DATA_W:0]      cmd_q_i,
    input  logic                        cmd_empty_i,
    output logic                        cmd_deq_o,
    input  logic [xga_mem_pkg::BURST_REQ_W-1:0] burst_q_i,
    input  logic                        burst_empty_i,
    output logic                        burst_deq_o,
    output logic [DATA_W-1:0]           rsp_d_o,
    output logic                        rsp_enq_o,
    input  logic                        rsp_full_i,
    output logic [BURST_LEN*DATA_W-1:0] rsp_burst_d_o,
    output logic                        rsp_burst_enq_o,
    input  logic                        rsp_burst_full_i,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_wdata_o,
    input  logic                        mem_ack_i,
    input  logic [DATA_W-1:0]           mem_rdata_i,
    output logic                        busy_o
);

    import xga_mem_pkg::*;

    state_e              state_q, state_d;
    logic                last_burst_q, last_burst_d;
    logic                push_burst_q, push_burst_d;
    logic                cmd_deq_q, cmd_deq_d;
    logic                burst_deq_q, burst_deq_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;
    logic                rsp_enq_q, rsp_enq_d;
    logic                rsp_burst_enq_q, rsp_burst_enq_d;

    logic                cmd_is_write;
    logic                single_ok;
    logic                burst_ok;
    logic                pick_burst;
    logic                pack_clear;
    logic                pack_valid;
    logic                pack_last;
    logic [BEAT_W-1:0]   beat;
    logic                burst_unused;

    // Eligibility: reads need a free single-response slot, bursts a free burst slot
    assign cmd_is_write = cmd_q_i[CMD_WE_BIT];
    assign single_ok    = !cmd_empty_i && (cmd_is_write || !rsp_full_i);
    assign burst_ok     = !burst_empty_i && !rsp_burst_full_i;
    // When both are ready, the class not served last goes first
    assign pick_burst   = burst_ok && (!single_ok || !last_burst_q);

    // The reserved upper byte of the burst request carries nothing for us
    assign burst_unused = ^burst_q_i[BURST_REQ_W-1:ADDR_W];

    // Next-state, strobe and datapath control
    always_comb begin
        state_d         = state_q;
        last_burst_d    = last_burst_q;
        push_burst_d    = push_burst_q;
        cmd_deq_d       = 1'b0;
        burst_deq_d     = 1'b0;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rsp_d           = rsp_q;
        rsp_enq_d       = 1'b0;
        rsp_burst_enq_d = 1'b0;
        pack_clear      = 1'b0;
        pack_valid      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_burst) begin
                    state_d      = BURST;
                    last_burst_d = 1'b1;
                    burst_deq_d  = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    addr_d       = burst_q_i[ADDR_W-1:0];
                    wdata_d      = '0;
                    pack_clear   = 1'b1;
                end else if (single_ok) begin
                    state_d      = SINGLE;
                    last_burst_d = 1'b0;
                    cmd_deq_d    = 1'b1;
                    mem_req_d    = 1'b1;
                    mem_we_d     = cmd_is_write;
                    addr_d       = cmd_q_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
                    wdata_d      = cmd_q_i[DATA_W-1:0];
                end
            end
            SINGLE: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        rsp_d        = mem_rdata_i;
                        push_burst_d = 1'b0;
                        state_d      = PUSH;
                    end
                end
            end
            BURST: begin
                if (mem_ack_i) begin
                    pack_valid = 1'b1;
                    if (pack_last) begin
                        mem_req_d    = 1'b0;
                        push_burst_d = 1'b1;
                        state_d      = PUSH;
                    end
                end
            end
            PUSH: begin
                rsp_enq_d       = !push_burst_q;
                rsp_burst_enq_d = push_burst_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= IDLE;
            last_burst_q    <= 1'b0;
            push_burst_q    <= 1'b0;
            cmd_deq_q       <= 1'b0;
            burst_deq_q     <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rsp_q           <= '0;
            rsp_enq_q       <= 1'b0;
            rsp_burst_enq_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_burst_q    <= last_burst_d;
            push_burst_q    <= push_burst_d;
            cmd_deq_q       <= cmd_deq_d;
            burst_deq_q     <= burst_deq_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rsp_q           <= rsp_d;
            rsp_enq_q       <= rsp_enq_d;
            rsp_burst_enq_q <= rsp_burst_enq_d;
        end
    end

    xga_burst_packer #(
        .DATA_W (DATA_W),
        .BEATS  (BURST_LEN)
    ) u_packer (
        .clk        (clk),
        .rst_n      (reset_n_i),
        .clear      (pack_clear),
        .beat_valid (pack_valid),
        .data       (mem_rdata_i),
        .data_128   (rsp_burst_d_o),
        .beat       (beat),
        .last_beat  (pack_last)
    );

    // Burst beats walk the aligned 8-word block, wrapping within it
    assign mem_addr_o      = (state_q == BURST) ? {addr_q[ADDR_W-1:BEAT_W], beat} : addr_q;
    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_wdata_o     = wdata_q;
    assign cmd_deq_o       = cmd_deq_q;
    assign burst_deq_o     = burst_deq_q;
    assign rsp_d_o         = rsp_q;
    assign rsp_enq_o       = rsp_enq_q;
    assign rsp_burst_enq_o = rsp_burst_enq_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_xga_mem_responder.sv
// Directed bench for xga_mem_responder: FIFO and memory models around the DUT,
// a vector table of single commands, and hand sequences for bursts,
// arbitration, response-full blocking and mid-burst reset.
module tb_xga_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n_i;
    logic [40:0]   cmd_q_i;
    logic          cmd_empty_i;
    logic          cmd_deq_o;
    logic [31:0]   burst_q_i;
    logic          burst_empty_i;
    logic          burst_deq_o;
    logic [15:0]   rsp_d_o;
    logic          rsp_enq_o;
    logic          rsp_full_i;
    logic [127:0]  rsp_burst_d_o;
    logic          rsp_burst_enq_o;
    logic          rsp_burst_full_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [23:0]   mem_addr_o;
    logic [15:0]   mem_wdata_o;
    logic          mem_ack_i;
    logic [15:0]   mem_rdata_i;
    logic          busy_o;

    xga_mem_responder dut (
        .clk              (clk),
        .reset_n_i        (reset_n_i),
        .cmd_q_i          (cmd_q_i),
        .cmd_empty_i      (cmd_empty_i),
        .cmd_deq_o        (cmd_deq_o),
        .burst_q_i        (burst_q_i),
        .burst_empty_i    (burst_empty_i),
        .burst_deq_o      (burst_deq_o),
        .rsp_d_o          (rsp_d_o),
        .rsp_enq_o        (rsp_enq_o),
        .rsp_full_i       (rsp_full_i),
        .rsp_burst_d_o    (rsp_burst_d_o),
        .rsp_burst_enq_o  (rsp_burst_enq_o),
        .rsp_burst_full_i (rsp_burst_full_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic        we;
        logic [23:0] addr;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] exp_rd;
    } vec_t;

    // Bench-side models and logs
    logic [15:0]  mem [0:4095];
    logic [40:0]  cmd_fifo [$];
    logic [31:0]  burst_fifo [$];
    logic [23:0]  acc_addr [$];
    logic         acc_we [$];
    logic [15:0]  acc_wdata [$];
    logic [15:0]  rsp_log [$];
    logic [127:0] brsp_log [$];
    bit           grant_log [$];
    int acc_n = 0, deq_n = 0, cyc = 0, deq_cyc = 0, enq_cyc = 0, benq_cyc = 0;
    int req_cyc = 0, hold_viol = 0, wait_cfg = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // FIFO heads, zero/N-wait memory responder and output monitor, all at negedge
    initial begin
        logic        prev_req;
        logic        prev_we;
        logic [23:0] prev_addr;
        logic [15:0] prev_wd;
        int          wcnt;
        prev_req = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_wd = '0; wcnt = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'hC000 | 16'(i);
        mem[12'h020] = 16'h1234;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        cmd_q_i = '0; cmd_empty_i = 1'b1; burst_q_i = '0; burst_empty_i = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (mem_req_o) req_cyc++;
            if (prev_req && !mem_ack_i && mem_req_o &&
                (mem_we_o !== prev_we || mem_addr_o !== prev_addr || mem_wdata_o !== prev_wd))
                hold_viol++;
            prev_req = mem_req_o; prev_we = mem_we_o; prev_addr = mem_addr_o; prev_wd = mem_wdata_o;
            if (cmd_deq_o) begin
                grant_log.push_back(1'b0); deq_n++; deq_cyc = cyc;
                if (cmd_fifo.size() > 0) cmd_fifo.delete(0);
            end
            if (burst_deq_o) begin
                grant_log.push_back(1'b1); deq_n++; deq_cyc = cyc;
                if (burst_fifo.size() > 0) burst_fifo.delete(0);
            end
            if (rsp_enq_o) begin
                rsp_log.push_back(rsp_d_o); enq_cyc = cyc;
            end
            if (rsp_burst_enq_o) begin
                brsp_log.push_back(rsp_burst_d_o); benq_cyc = cyc;
            end
            mem_ack_i = 1'b0;
            if (mem_req_o && reset_n_i) begin
                if (wcnt < wait_cfg) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem[mem_addr_o[11:0]];
                    if (mem_we_o) mem[mem_addr_o[11:0]] = mem_wdata_o;
                    acc_addr.push_back(mem_addr_o);
                    acc_we.push_back(mem_we_o);
                    acc_wdata.push_back(mem_wdata_o);
                    acc_n++;
                end
            end else begin
                wcnt = 0;
            end
            cmd_empty_i   = (cmd_fifo.size() == 0);
            cmd_q_i       = cmd_empty_i ? 41'd0 : cmd_fifo[0];
            burst_empty_i = (burst_fifo.size() == 0);
            burst_q_i     = burst_empty_i ? 32'd0 : burst_fifo[0];
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int t;
        t = 0;
        repeat (3) @(negedge clk);
        while (!(cmd_fifo.size() == 0 && burst_fifo.size() == 0 && !busy_o &&
                 !rsp_enq_o && !rsp_burst_enq_o) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check_i({tag, " finished in budget"}, (t < budget) ? 1 : 0, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_burst(input string tag, input int a0, input logic [23:0] blk,
                               input int b0, input logic [127:0] exp_data);
        check_i({tag, " access count"}, acc_n - a0, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s beat %0d addr", tag, k), 128'(acc_addr[a0 + k]),
                  128'(blk + 24'(k)));
            check($sformatf("%s beat %0d we", tag, k), 128'(acc_we[a0 + k]), 128'(1'b0));
        end
        check_i({tag, " enq count"}, brsp_log.size() - b0, 1);
        check({tag, " data"}, brsp_log[brsp_log.size() - 1], exp_data);
    endtask

    vec_t vecs [6];
    int   d0, a0, r0, b0, g0, q0, t0;

    initial begin
        vecs[0] = '{1'b1, 24'h000010, 16'hBEEF, 2, 16'h0000};
        vecs[1] = '{1'b0, 24'h000020, 16'h0000, 3, 16'h1234};
        vecs[2] = '{1'b0, 24'h000010, 16'h0000, 0, 16'hBEEF};
        vecs[3] = '{1'b1, 24'hF00ABC, 16'h0F0F, 1, 16'h0000};
        vecs[4] = '{1'b0, 24'hF00ABC, 16'h0000, 0, 16'h0F0F};
        vecs[5] = '{1'b0, 24'h0007FF, 16'h0000, 1, 16'hC7FF};

        rsp_full_i = 1'b0; rsp_burst_full_i = 1'b0;
        reset_n_i = 1'b1;
        #2 reset_n_i = 1'b0;
        #20;
        check("reset outputs", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, cmd_deq_o,
              burst_deq_o, rsp_enq_o, rsp_burst_enq_o, rsp_d_o, busy_o}), 128'd0);
        check("reset burst data", rsp_burst_d_o, 128'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // Single command vectors
        for (int v = 0; v < 6; v++) begin
            d0 = deq_n; a0 = acc_n; r0 = rsp_log.size();
            wait_cfg = vecs[v].waits;
            cmd_fifo.push_back({vecs[v].we, vecs[v].addr, vecs[v].wdata});
            wait_idle(200, $sformatf("v%0d", v));
            $display("vec %0d: we=%0b addr=%06h wdata=%04h waits=%0d rsp=%0d", v, vecs[v].we,
                     vecs[v].addr, vecs[v].wdata, vecs[v].waits, rsp_log.size() - r0);
            check_i($sformatf("v%0d deq count", v), deq_n - d0, 1);
            check_i($sformatf("v%0d access count", v), acc_n - a0, 1);
            check($sformatf("v%0d addr", v), 128'(acc_addr[acc_addr.size() - 1]), 128'(vecs[v].addr));
            check($sformatf("v%0d we", v), 128'(acc_we[acc_we.size() - 1]), 128'(vecs[v].we));
            check($sformatf("v%0d req low after ack", v), 128'(mem_req_o), 128'(1'b0));
            if (vecs[v].we) begin
                check($sformatf("v%0d wdata", v), 128'(acc_wdata[acc_wdata.size() - 1]),
                      128'(vecs[v].wdata));
                check_i($sformatf("v%0d rsp count", v), rsp_log.size() - r0, 0);
            end else begin
                check_i($sformatf("v%0d rsp count", v), rsp_log.size() - r0, 1);
                check($sformatf("v%0d rsp data", v), 128'(rsp_log[rsp_log.size() - 1]),
                      128'(vecs[v].exp_rd));
                check_i($sformatf("v%0d latency", v), enq_cyc - deq_cyc, vecs[v].waits + 2);
            end
        end

        // Arbitration: bursts and reads both pending, last served was a single
        wait_cfg = 0;
        g0 = grant_log.size(); r0 = rsp_log.size(); b0 = brsp_log.size();
        burst_fifo.push_back(32'h0000_0200);
        burst_fifo.push_back(32'h0000_0308);
        cmd_fifo.push_back({1'b0, 24'h000021, 16'h0000});
        cmd_fifo.push_back({1'b0, 24'h000022, 16'h0000});
        wait_idle(400, "arb");
        $display("arb: %0d grants, %0d single rsp, %0d burst rsp", grant_log.size() - g0,
                 rsp_log.size() - r0, brsp_log.size() - b0);
        check_i("arb grant count", grant_log.size() - g0, 4);
        for (int k = 0; k < 4; k++)
            check_i($sformatf("arb grant %0d is burst", k), int'(grant_log[g0 + k]), (k % 2 == 0) ? 1 : 0);
        check_i("arb rsp count", rsp_log.size() - r0, 2);
        check("arb rsp 0", 128'(rsp_log[r0]), 128'(16'hC021));
        check("arb rsp 1", 128'(rsp_log[r0 + 1]), 128'(16'hC022));
        check_i("arb burst count", brsp_log.size() - b0, 2);
        check("arb burst 0", brsp_log[b0], 128'hC207_C206_C205_C204_C203_C202_C201_C200);
        check("arb burst 1", brsp_log[b0 + 1], 128'hC30F_C30E_C30D_C30C_C30B_C30A_C309_C308);

        // Unaligned burst base, zero-wait memory
        a0 = acc_n; b0 = brsp_log.size();
        burst_fifo.push_back(32'h0000_0105);
        wait_idle(200, "burst");
        $display("burst 0x000105: %0d accesses, data %032h", acc_n - a0, brsp_log[brsp_log.size() - 1]);
        check_burst("burst", a0, 24'h000100, b0, 128'hC107_C106_C105_C104_C103_C102_C101_C100);
        check_i("burst latency", benq_cyc - deq_cyc, 9);

        // Response FIFO full blocks a read and the write queued behind it
        rsp_full_i = 1'b1;
        d0 = deq_n; a0 = acc_n; q0 = req_cyc; r0 = rsp_log.size();
        cmd_fifo.push_back({1'b0, 24'h000030, 16'h0000});
        cmd_fifo.push_back({1'b1, 24'h000031, 16'h5555});
        repeat (20) @(negedge clk);
        #1;
        check_i("full deq count", deq_n - d0, 0);
        check_i("full req cycles", req_cyc - q0, 0);
        rsp_full_i = 1'b0;
        wait_idle(200, "full");
        $display("full release: %0d grants, first addr %06h", deq_n - d0, acc_addr[a0]);
        check_i("full release deq count", deq_n - d0, 2);
        check("full first addr", 128'(acc_addr[a0]), 128'(24'h000030));
        check("full first we", 128'(acc_we[a0]), 128'(1'b0));
        check("full second addr", 128'(acc_addr[a0 + 1]), 128'(24'h000031));
        check("full second we", 128'(acc_we[a0 + 1]), 128'(1'b1));
        check("full rsp data", 128'(rsp_log[r0]), 128'(16'hC030));

        // Reset asserted in beat 4 of a burst, then a clean burst afterwards
        wait_cfg = 0;
        a0 = acc_n; b0 = brsp_log.size();
        burst_fifo.push_back(32'h0000_0400);
        t0 = 0;
        while (acc_n < a0 + 4 && t0 < 100) begin
            @(negedge clk);
            #1;
            t0++;
        end
        check_i("reset beat4 reached", (acc_n >= a0 + 4) ? 1 : 0, 1);
        @(posedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        $display("mid-burst reset after %0d beats", acc_n - a0);
        check("midreset outputs", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, cmd_deq_o,
              burst_deq_o, rsp_enq_o, rsp_burst_enq_o, rsp_d_o, busy_o}), 128'd0);
        check("midreset burst data", rsp_burst_d_o, 128'd0);
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        check_i("midreset no burst enq", brsp_log.size() - b0, 0);
        wait_cfg = 1;
        a0 = acc_n; b0 = brsp_log.size();
        burst_fifo.push_back(32'h0000_0408);
        wait_idle(300, "post-reset burst");
        $display("post-reset burst 0x000408: %0d accesses, data %032h", acc_n - a0,
                 brsp_log[brsp_log.size() - 1]);
        check_burst("post-reset burst", a0, 24'h000408, b0, 128'hC40F_C40E_C40D_C40C_C40B_C40A_C409_C408);

        check_i("mem fields held while waiting", hold_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xga_mem_responder.md
Name: xga_mem_responder

Overview:
- Memory-side consumer of the XGA command/response FIFO protocol: dequeues single-word write/read commands and burst-read requests, executes them on a 16-bit req/ack memory port, and enqueues read data into the single-word (16-bit) or burst (128-bit) response FIFOs.
- Sits between the writer/reader FIFOs and the SDRAM controller front-end; it is the responder for the framebuffer-side initiator.

Parameters:
- ADDR_W, 24, word address width.
- DATA_W, 16, memory word width.
- BURST_LEN, 8, words per burst read. Response width = BURST_LEN*DATA_W = 128. Only the default values are supported and verified.

Ports:
- clk  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- cmd_q_i  in  41  single command: [40]=write, [39:16]=word address, [15:0]=write data (ignored for reads)
- cmd_empty_i  in  1  single command FIFO empty (first-word fall-through, so cmd_q_i is valid whenever !empty)
- cmd_deq_o  out  1  pop single command FIFO
- burst_q_i  in  32  burst request: [23:0]=word address, [2:0] ignored (8-word aligned), [31:24] reserved
- burst_empty_i  in  1  burst request FIFO empty (first-word fall-through)
- burst_deq_o  out  1  pop burst request FIFO
- rsp_d_o  out  16  single read data
- rsp_enq_o  out  1  push single response FIFO
- rsp_full_i  in  1  single response FIFO full
- rsp_burst_d_o  out  128  burst read data; word 0 in [15:0]
- rsp_burst_enq_o  out  1  push burst response FIFO
- rsp_burst_full_i  in  1  burst response FIFO full
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write
- mem_addr_o  out  24  word address
- mem_wdata_o  out  16  write data
- mem_ack_i  in  1  access complete; for reads, mem_rdata_i is valid in the same cycle
- mem_rdata_i  in  16  read data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: every output is 0; state = IDLE; last_burst flag = 0. Reset asserted mid-transaction abandons the access (mem_req_o drops asynchronously), discards partially assembled burst data, and leaves FIFO contents unchanged except for pops already performed.
- States: IDLE, SINGLE, BURST, PUSH.
- Eligibility, evaluated in IDLE only:
  - A single command is eligible if !cmd_empty_i and, for a read, !rsp_full_i.
  - A burst request is eligible if !burst_empty_i and !rsp_burst_full_i.
  - Response space is checked at grant; one transaction is outstanding at most, so a granted read always has a response slot.
- Arbitration: if both are eligible, serve the class not served last (last_burst flag toggles per grant). If only one is eligible, serve it. If neither is eligible, stay in IDLE with all strobes low.
- Grant edge:
  - Latch the command fields.
  - Register a one-cycle deq pulse, high in the first cycle of the new state.
  - Set mem_req_o=1 with address, we and data driven.
  - Next state is SINGLE or BURST.
- SINGLE:
  - Hold mem_req_o and all mem fields stable until mem_ack_i.
  - On ack of a write: mem_req_o<=0, go to IDLE.
  - On ack of a read: latch mem_rdata_i into rsp_d_o, mem_req_o<=0, go to PUSH.
- BURST:
  - Beat counter runs 0..7; mem_addr_o = {base[23:3], beat}, so addresses wrap inside the aligned 8-word block.
  - Each ack stores mem_rdata_i into slot beat, increments beat, and keeps mem_req_o high.
  - On the 8th ack: mem_req_o<=0, go to PUSH.
- PUSH:
  - Assert rsp_enq_o or rsp_burst_enq_o for exactly one cycle, with data stable, then return to IDLE.
  - The next grant can occur in the following cycle.
- mem_ack_i with mem_req_o low is ignored.
- Latency:
  - Single read with zero-wait memory (ack in the first req cycle): grant edge to rsp_enq_o high = 2 cycles.
  - Burst with zero-wait memory: 8 ack cycles, then 1 PUSH cycle.
- busy_o = (state != IDLE).

Decomposition:
- Package xga_mem_pkg holds:
  - CMD_W=41, CMD_WE_BIT=40, CMD_ADDR_MSB/LSB=39/16.
  - BURST_REQ_W=32, BURST_LEN=8.
  - State enum typedef (IDLE, SINGLE, BURST, PUSH).
- One natural sub-module: xga_burst_packer. It holds the beat counter and the 128-bit assembly register, with inputs clear/beat_valid/data and outputs data_128/last_beat.

Test Plan:
- Single write cmd {1,24'h000010,16'hBEEF} -> cmd_deq_o one pulse; mem_req_o=1, we=1, addr=0x000010, wdata=0xBEEF held until ack; no rsp_enq_o.
- Single read addr 0x000020, memory returns 0x1234 after 3 wait cycles -> rsp_enq_o single pulse with rsp_d_o=0x1234; mem_req_o low after ack.
- Burst addr 0x000105 -> addresses 0x100..0x107 in order; rsp_burst_d_o[15:0] = word at 0x100 and [127:112] = word at 0x107; one rsp_burst_enq_o.
- Burst and read pending continuously -> grants alternate burst, single, burst, single; no class starved.
- rsp_full_i=1 with a pending read plus a pending write behind it -> nothing dequeued and mem_req_o stays 0; releasing full -> read served first.
- reset_n_i low during burst beat 4 -> all outputs 0 immediately; after release, a new burst produces correct 8-word data with no stale beats.
